// File: rtl/bptable_init_ctrl.sv
// rtl/bptable_init_ctrl.sv - branch predictor table init walker and write-port arbiter
// Walks PHT/BHT after reset or InitReqE, otherwise forwards committed W-stage updates.
module bptable_init_ctrl #(
  parameter int          k        = 10,
  parameter int          m        = 6,
  parameter logic [1:0]  PHT_INIT = 2'b01
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          InitReqE,
  input  logic          StallW,
  input  logic          FlushW,
  input  logic          UpdEnW,
  input  logic [k-1:0]  UpdPHTAddrW,
  input  logic [1:0]    UpdPHTDataW,
  input  logic [m-1:0]  UpdBHTAddrW,
  input  logic [k-1:0]  UpdBHTDataW,
  output logic          PHTWe,
  output logic [k-1:0]  PHTWa,
  output logic [1:0]    PHTWd,
  output logic          BHTWe,
  output logic [m-1:0]  BHTWa,
  output logic [k-1:0]  BHTWd,
  output logic          SHBClear,
  output logic          BPBusy,
  output logic          InitDone
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;

  localparam logic [k-1:0] CNT_LAST  = '1;
  localparam logic [k:0]   BHT_DEPTH = (k+1)'(1) << m;

  logic [0:0]   state_q, state_d;
  logic [k-1:0] cnt_q, cnt_d;
  logic         shb_q, shb_d;
  logic         done_q, done_d;
  logic         upd_fire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shb_d   = 1'b0;
    done_d  = 1'b0;
    if (state_q == S_CLEAR) begin
      // A restart request wins even on the final walk cycle, suppressing InitDone.
      if (InitReqE) begin
        cnt_d = '0;
        shb_d = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (InitReqE) begin
      state_d = S_CLEAR;
      cnt_d   = '0;
      shb_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      shb_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shb_q   <= shb_d;
      done_q  <= done_d;
    end
  end

  assign upd_fire = UpdEnW & ~StallW & ~FlushW;

  always_comb begin
    PHTWe    = 1'b0;
    PHTWa    = UpdPHTAddrW;
    PHTWd    = UpdPHTDataW;
    BHTWe    = 1'b0;
    BHTWa    = UpdBHTAddrW;
    BHTWd    = UpdBHTDataW;
    SHBClear = 1'b0;
    InitDone = 1'b0;
    BPBusy   = 1'b1;
    if (!reset) begin
      if (state_q == S_CLEAR) begin
        PHTWe    = 1'b1;
        PHTWa    = cnt_q;
        PHTWd    = PHT_INIT;
        BHTWe    = ({1'b0, cnt_q} < BHT_DEPTH);
        BHTWa    = cnt_q[m-1:0];
        BHTWd    = '0;
        SHBClear = shb_q;
      end else begin
        PHTWe    = upd_fire;
        BHTWe    = upd_fire;
        InitDone = done_q;
        BPBusy   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bptable_init_ctrl.sv
// tb/tb_bptable_init_ctrl.sv - randomized directed bench with walk-position reference model
module tb_bptable_init_ctrl;

  localparam int K = 10;
  localparam int M = 6;
  localparam int PHT_DEPTH = 1 << K;
  localparam int BHT_DEPTH = 1 << M;

  logic         clk = 1'b0;
  logic         reset, InitReqE, StallW, FlushW, UpdEnW;
  logic [K-1:0] UpdPHTAddrW, UpdBHTDataW;
  logic [1:0]   UpdPHTDataW;
  logic [M-1:0] UpdBHTAddrW;
  logic         PHTWe, BHTWe, SHBClear, BPBusy, InitDone;
  logic [K-1:0] PHTWa, BHTWd;
  logic [1:0]   PHTWd;
  logic [M-1:0] BHTWa;

  int errors = 0;
  int checks = 0;

  // Reference: walking flag, table position being written, pending pulses.
  bit m_walking;
  int m_pos;
  bit m_shb;
  bit m_done;

  int cyc = 0;
  int busy_cycles = 0;
  int done_cycle  = -1;

  always #5 clk = ~clk;

  bptable_init_ctrl #(.k(K), .m(M), .PHT_INIT(2'b01)) dut (
    .clk(clk), .reset(reset), .InitReqE(InitReqE), .StallW(StallW), .FlushW(FlushW),
    .UpdEnW(UpdEnW), .UpdPHTAddrW(UpdPHTAddrW), .UpdPHTDataW(UpdPHTDataW),
    .UpdBHTAddrW(UpdBHTAddrW), .UpdBHTDataW(UpdBHTDataW),
    .PHTWe(PHTWe), .PHTWa(PHTWa), .PHTWd(PHTWd), .BHTWe(BHTWe), .BHTWa(BHTWa), .BHTWd(BHTWd),
    .SHBClear(SHBClear), .BPBusy(BPBusy), .InitDone(InitDone)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit ini, input bit upd, input bit st, input bit fl,
                       input logic [K-1:0] pa, input logic [1:0] pd,
                       input logic [M-1:0] ba, input logic [K-1:0] bd);
    bit fire;
    reset = r; InitReqE = ini; UpdEnW = upd; StallW = st; FlushW = fl;
    UpdPHTAddrW = pa; UpdPHTDataW = pd; UpdBHTAddrW = ba; UpdBHTDataW = bd;
    @(negedge clk);
    if (r) begin
      chk("rst_phtwe", 32'(PHTWe), 0);
      chk("rst_bhtwe", 32'(BHTWe), 0);
      chk("rst_busy", 32'(BPBusy), 1);
      chk("rst_shb", 32'(SHBClear), 0);
      chk("rst_done", 32'(InitDone), 0);
    end else if (m_walking) begin
      chk("walk_phtwe", 32'(PHTWe), 1);
      chk("walk_phtwa", 32'(PHTWa), 32'(m_pos));
      chk("walk_phtwd", 32'(PHTWd), 1);
      chk("walk_bhtwe", 32'(BHTWe), 32'(m_pos < BHT_DEPTH));
      chk("walk_bhtwa", 32'(BHTWa), 32'(m_pos % BHT_DEPTH));
      chk("walk_bhtwd", 32'(BHTWd), 0);
      chk("walk_busy", 32'(BPBusy), 1);
      chk("walk_shb", 32'(SHBClear), 32'(m_shb));
      chk("walk_done", 32'(InitDone), 0);
    end else begin
      fire = upd && !st && !fl;
      chk("idle_phtwe", 32'(PHTWe), 32'(fire));
      chk("idle_bhtwe", 32'(BHTWe), 32'(fire));
      if (fire) begin
        chk("idle_phtwa", 32'(PHTWa), 32'(pa));
        chk("idle_phtwd", 32'(PHTWd), 32'(pd));
        chk("idle_bhtwa", 32'(BHTWa), 32'(ba));
        chk("idle_bhtwd", 32'(BHTWd), 32'(bd));
      end
      chk("idle_busy", 32'(BPBusy), 0);
      chk("idle_shb", 32'(SHBClear), 0);
      chk("idle_done", 32'(InitDone), 32'(m_done));
    end
    if (BPBusy === 1'b1) busy_cycles++;
    if (InitDone === 1'b1) done_cycle = cyc;
    @(posedge clk);
    m_shb  = 0;
    m_done = 0;
    if (r) begin
      m_walking = 1; m_pos = 0; m_shb = 1;
    end else if (ini) begin
      m_walking = 1; m_pos = 0; m_shb = 1;
    end else if (m_walking) begin
      if (m_pos == PHT_DEPTH - 1) begin
        m_walking = 0; m_done = 1;
      end else begin
        m_pos++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic rnd_step(input bit r, input bit ini);
    drive(r, ini, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
          K'($urandom), 2'($urandom), M'($urandom), K'($urandom));
  endtask

  initial begin
    m_walking = 0; m_pos = 0; m_shb = 0; m_done = 0;
    reset = 1; InitReqE = 0; StallW = 0; FlushW = 0; UpdEnW = 0;
    UpdPHTAddrW = '0; UpdPHTDataW = '0; UpdBHTAddrW = '0; UpdBHTDataW = '0;
    #1;

    // Power-up walk: cycle 0 is reset, walk cycles 1..1024, InitDone at 1025.
    rnd_step(1, 0);
    busy_cycles = 0;
    for (int i = 0; i < PHT_DEPTH + 4; i++) rnd_step(0, 0);
    chk("walk_len", 32'(busy_cycles), 32'(PHT_DEPTH));
    chk("done_cycle", 32'(done_cycle), 32'(PHT_DEPTH + 1));

    // Directed pass-through, then stalled and flushed variants.
    drive(0, 0, 1, 0, 0, 10'h155, 2'b11, 6'h2A, 10'h3FF);
    drive(0, 0, 1, 1, 0, 10'h155, 2'b11, 6'h2A, 10'h3FF);
    drive(0, 0, 1, 0, 1, 10'h155, 2'b11, 6'h2A, 10'h3FF);
    for (int i = 0; i < 40; i++) rnd_step(0, 0);

    // Init from IDLE alongside an update, then restart at position 500.
    drive(0, 1, 1, 0, 0, 10'h0AB, 2'b10, 6'h15, 10'h123);
    while (m_walking && m_pos != 500) rnd_step(0, 0);
    rnd_step(0, 1);
    done_cycle = -1;
    busy_cycles = 0;
    for (int i = 0; i < PHT_DEPTH + 2; i++) rnd_step(0, 0);
    chk("restart_len", 32'(busy_cycles), 32'(PHT_DEPTH));
    chk("restart_done", 32'(done_cycle >= 0), 1);

    // Request on the last walk cycle: no InitDone, walk restarts.
    rnd_step(0, 1);
    while (m_walking && m_pos != PHT_DEPTH - 1) rnd_step(0, 0);
    done_cycle = -1;
    rnd_step(0, 1);
    rnd_step(0, 0);
    chk("last_no_done", 32'(done_cycle), 32'hFFFF_FFFF);
    chk("last_restart_pos", 32'(PHTWa), 32'(1));

    // Reset together with InitReqE mid-walk, then a held request for a few cycles.
    while (m_walking && m_pos != 300) rnd_step(0, 0);
    rnd_step(1, 1);
    for (int i = 0; i < 6; i++) rnd_step(0, 1);
    while (m_walking) rnd_step(0, 0);
    for (int i = 0; i < 8; i++) rnd_step(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bptable_init_ctrl.md
Name: bptable_init_ctrl

Overview:
- Sequencer and write-port arbiter for the local-history branch predictor tables: PHT (2^k x 2-bit counters) and BHT (2^m x k-bit local histories).
- After reset, or on an explicit request, it walks every PHT and BHT address and writes the initial values.
- While idle, it passes committed W-stage predictor updates through to the tables' single write ports.
- It clears the speculative-history valid bits and holds fetch until the tables are consistent.

Parameters:
- k, 10, PHT index width; PHT depth is 2^k.
- m, 6, BHT index width; BHT depth is 2^m. Legal range is 1..k.
- PHT_INIT, 2'b01, initial PHT counter value (weakly not-taken).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- InitReqE  in  1  request to re-initialize the tables (e.g. fence.i/predictor flush CSR); level is sampled each cycle
- StallW  in  1  W-stage stall
- FlushW  in  1  W-stage flush
- UpdEnW  in  1  committed branch update request (BranchM-qualified in W)
- UpdPHTAddrW  in  k  PHT update address (LHRW)
- UpdPHTDataW  in  2  new PHT counter value
- UpdBHTAddrW  in  m  BHT update address
- UpdBHTDataW  in  k  new local history
- PHTWe  out  1  PHT write enable
- PHTWa  out  k  PHT write address
- PHTWd  out  2  PHT write data
- BHTWe  out  1  BHT write enable
- BHTWa  out  m  BHT write address
- BHTWd  out  k  BHT write data
- SHBClear  out  1  one-cycle pulse; sets all speculative-history FlushedBits
- BPBusy  out  1  predictor unavailable; fetch stalls / predicts not-taken
- InitDone  out  1  one-cycle pulse when a walk completes

Behaviour:
- State machine has two states: CLEAR and IDLE. An internal walk counter Cnt is k bits wide.
- Reset:
  - State goes to CLEAR, Cnt = 0, SHBClear = 1 in the first cycle after reset.
  - During the reset cycle itself: all write enables = 0, BPBusy = 1, InitDone = 0, SHBClear = 0.
- CLEAR, each cycle:
  - PHTWe = 1, PHTWa = Cnt, PHTWd = PHT_INIT.
  - BHTWe = (Cnt < 2^m), BHTWa = Cnt[m-1:0], BHTWd = 0.
  - BPBusy = 1. Cnt increments by 1.
  - The walk ignores StallW and FlushW; it never waits on the pipeline.
- CLEAR exit:
  - The cycle with Cnt == 2^k-1 writes the last entry.
  - The next cycle is IDLE with InitDone = 1 for that one cycle.
  - Total walk is exactly 2^k write cycles. The BHT is complete after 2^m cycles.
- CLEAR entry: SHBClear pulses for exactly one cycle, in the first CLEAR cycle. This holds for both reset and InitReqE entries.
- IDLE, each cycle:
  - PHTWe = BHTWe = UpdEnW & ~StallW & ~FlushW.
  - PHTWa/Wd = UpdPHTAddrW/UpdPHTDataW and BHTWa/Wd = UpdBHTAddrW/UpdBHTDataW, all combinational, zero-latency pass-through.
  - BPBusy = 0.
- InitReqE while IDLE: the next cycle is CLEAR with Cnt = 0. A commit update presented in the same cycle as InitReqE is still written.
- InitReqE while CLEAR:
  - The walk restarts: next Cnt = 0 and SHBClear pulses again.
  - This includes the last walk cycle (Cnt == 2^k-1); in that case there is no InitDone and the controller stays in CLEAR.
- Commit updates while CLEAR: dropped silently; no write and no buffering. The table is being reset, so the update is stale.
- Held InitReqE: the walk keeps restarting every cycle. BPBusy stays 1 and InitDone never fires until the request is released.
- Reset mid-walk: reset behaviour as above; reset has priority over InitReqE.
- Counter wrap: Cnt never wraps silently. Reaching 2^k-1 forces the IDLE transition unless InitReqE restarts the walk.
- Outputs are registered state plus the combinational muxing described above. There are no X outputs after reset.

Test Plan:
- Reset 1 cycle, then run with no requests:
  - BPBusy = 1 for 1024 cycles; PHTWa steps 0..1023 with PHTWd = 01.
  - BHTWe = 1 for the first 64 cycles only, BHTWd = 0.
  - SHBClear pulses in cycle 1; InitDone pulses in cycle 1025, then BPBusy = 0.
- IDLE with UpdEnW = 1, UpdPHTAddrW = 0x155, data 11, UpdBHTAddrW = 0x2A, data 0x3FF:
  - PHTWe = BHTWe = 1 in the same cycle with matching addresses and data.
  - Repeat with StallW = 1, then with FlushW = 1: no write in either case.
- InitReqE pulsed at Cnt = 500 during the walk:
  - Cnt returns to 0 and SHBClear pulses again.
  - 1024 further write cycles follow before InitDone.
  - UpdEnW asserted during the walk produces no write carrying the update address/data.
- InitReqE pulsed in IDLE together with UpdEnW = 1:
  - The update is written that cycle.
  - Next cycle is CLEAR with PHTWa = 0 and SHBClear = 1.
- InitReqE asserted at Cnt = 1023: no InitDone; the walk restarts at 0.
- Reset asserted at Cnt = 300 with InitReqE = 1: the walk restarts from 0 exactly as after power-up.
